uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the core's data-memory port, selected by an external address decoder alongside data_ram. The core writes bytes into a small transmit FIFO. An 8N1 serialiser drains the FIFO onto txd_o at a programmable bit rate. A level interrupt reports "transmitter drained" and is routed to core interrupt line int[1], next to the timer interrupt on int[0].

---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and serialiser state
// encoding for the memory-mapped UART transmitter.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_MSB = 8;

    localparam int CTRL_IE      = 0;
    localparam int CTRL_OVF_CLR = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO; head is presented combinationally on dout so
// it can be consumed in the same cycle as pop.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need a known value,
    // and leaving the array unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, FIFO, serialiser FSM
// with a down-counting bit-rate timer, sticky overflow and drained interrupt.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o,
    output logic        txd_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

    logic [1:0]    reg_sel;
    logic          wr_strobe;
    logic          push;
    logic          ctrl_wr;
    logic          pop;
    logic          busy;

    logic [7:0]    fifo_dout;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    logic          overflow;
    logic          ie;

    tx_state_t     state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:1], data_i[31:8]};

    assign reg_sel   = addr[3:2];
    assign wr_strobe = ce & we & sel[0];
    assign push      = wr_strobe & (reg_sel == REG_TXDATA);
    assign ctrl_wr   = wr_strobe & (reg_sel == REG_CTRL);
    assign pop       = (state == ST_IDLE) & ~empty;
    assign busy      = (state != ST_IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            ie       <= 1'b0;
        end else begin
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr & data_i[CTRL_OVF_CLR]) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                ie <= data_i[CTRL_IE];
            end
        end
    end

    // txd_o is registered and loaded with the level of the segment being
    // entered, so the line never glitches and resets straight to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd_o   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_dout;
                        bit_cnt <= BIT_RELOAD;
                        txd_o   <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_RELOAD;
                        bit_idx <= '0;
                        txd_o   <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            txd_o <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            txd_o   <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    txd_o <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_o <= 1'b0;
        end else begin
            int_o <= ie & empty & ~busy & ~pop;
        end
    end

    // NOTE: data_o gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        data_o = '0;
        if (ce & ~we) begin
            case (reg_sel)
                REG_STATUS: begin
                    data_o[STAT_FULL]                 = full;
                    data_o[STAT_EMPTY]                = empty;
                    data_o[STAT_BUSY]                 = busy;
                    data_o[STAT_OVF]                  = overflow;
                    data_o[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(count);
                end
                REG_CTRL: begin
                    data_o[CTRL_IE] = ie;
                end
                default: begin
                    data_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLK_DIV=4, FIFO_DEPTH=8; outputs are
// sampled on the falling edge, inputs driven just after it.
module tb_uart_tx_mmio;

    localparam int CLK_DIV = 4;
    localparam logic [31:0] A_TXDATA = 32'h0000_0000;
    localparam logic [31:0] A_STATUS = 32'h0000_0004;
    localparam logic [31:0] A_CTRL   = 32'h0000_0008;
    localparam logic [31:0] A_RSVD   = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        int_o;
    logic        txd_o;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_mmio #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .int_o  (int_o),
        .txd_o  (txd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the write lands on the next rising edge.
    task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_o;
        ce = 1'b0;
    endtask

    // Waits for a start bit, then samples each data bit mid-period.
    task automatic rx_frame(output logic [7:0] b);
        int waited;
        b = '0;
        waited = 0;
        while (txd_o !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (txd_o !== 1'b0) begin
            check("rx_start_timeout", {31'd0, txd_o}, 32'd0);
            return;
        end
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            if (k >= 5 && k <= 33 && (k % 4) == 1) begin
                b[(k - 5) / 4] = txd_o;
            end
        end
        check("rx_stop_bit", {31'd0, txd_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        logic [7:0]  rxb;
        int          lows;
        bit          went_idle;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", {31'd0, txd_o}, 32'd1);
        check("rst_int", {31'd0, int_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_txd", {31'd0, txd_o}, 32'd1);
        check("idle_int", {31'd0, int_o}, 32'd0);
        read_reg(A_STATUS, rd);     check("idle_status", rd, 32'h002);
        read_reg(32'hFFFF_FFF4, rd); check("status_alias", rd, 32'h002);
        read_reg(A_TXDATA, rd);     check("txdata_read", rd, 32'h0);
        read_reg(A_CTRL, rd);       check("ctrl_reset", rd, 32'h0);
        read_reg(A_RSVD, rd);       check("rsvd_read", rd, 32'h0);
        ce = 1'b1; we = 1'b1; addr = A_STATUS; sel = 4'h0;
        #1;
        check("data_o_on_write", data_o, 32'h0);
        ce = 1'b0; we = 1'b0;

        // Lane 0 disabled: push must be ignored
        write_reg(A_TXDATA, 32'h77, 4'b1110);
        read_reg(A_STATUS, rd);     check("sel0_ignored", rd, 32'h002);

        // Single frame 0x55 with exact bit timing
        write_reg(A_TXDATA, 32'h55, 4'h1);
        check("lat_pre_txd", {31'd0, txd_o}, 32'd1);
        read_reg(A_STATUS, rd);     check("lat_pre_status", rd, 32'h010);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            @(negedge clk);
            check($sformatf("frame55_k%0d", k), {31'd0, txd_o}, {31'd0, frame[k / CLK_DIV]});
            if (k == 0 || k == 10 * CLK_DIV - 1) begin
                read_reg(A_STATUS, rd);
                check($sformatf("frame55_busy_k%0d", k), rd, 32'h006);
            end
        end
        @(negedge clk);
        check("frame55_end_txd", {31'd0, txd_o}, 32'd1);
        read_reg(A_STATUS, rd);     check("frame55_done", rd, 32'h002);

        // Overflow: ten writes, 0x0A dropped, nine frames emitted in order
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    write_reg(A_TXDATA, i, 4'h1);
                end
                read_reg(A_STATUS, rd);  check("ovf_status", rd, 32'h08D);
                write_reg(A_CTRL, 32'h3, 4'h1);
                read_reg(A_STATUS, rd);  check("ovf_cleared", rd, 32'h085);
                read_reg(A_CTRL, rd);    check("ctrl_ie_read", rd, 32'h1);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame(rxb);
                    check($sformatf("ovf_frame%0d", i), {24'd0, rxb}, i + 1);
                end
            end
        join
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd_o === 1'b0) lows++;
        end
        check("no_dropped_frame", lows, 32'd0);
        read_reg(A_STATUS, rd);     check("drained_status", rd, 32'h002);
        check("drained_int", {31'd0, int_o}, 32'd1);

        // Interrupt behaviour around one frame
        write_reg(A_TXDATA, 32'hA5, 4'h1);
        went_idle = 1'b0;
        for (int c = 0; c < 100 && !went_idle; c++) begin
            @(negedge clk);
            read_reg(A_STATUS, rd);
            if (rd[2] == 1'b0) begin
                went_idle = 1'b1;
            end else begin
                check("int_low_busy", {31'd0, int_o}, 32'd0);
            end
        end
        check("idle_reached", {31'd0, rd[2]}, 32'd0);
        check("int_at_idle_edge", {31'd0, int_o}, 32'd0);
        @(negedge clk);
        check("int_rise", {31'd0, int_o}, 32'd1);
        write_reg(A_CTRL, 32'h0, 4'h1);
        check("int_hold", {31'd0, int_o}, 32'd1);
        @(negedge clk);
        check("int_fall", {31'd0, int_o}, 32'd0);

        // Reset mid-frame during DATA
        write_reg(A_TXDATA, 32'h00, 4'h1);
        write_reg(A_TXDATA, 32'h00, 4'h1);
        repeat (8) @(negedge clk);
        check("pre_rst_txd", {31'd0, txd_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_async_txd", {31'd0, txd_o}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        read_reg(A_STATUS, rd);     check("post_rst_status", rd, 32'h002);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd_o === 1'b0) lows++;
        end
        check("post_rst_no_frame", lows, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
